// File: rtl/core_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/[MEM]/WB control strobes and retired-instruction counter.
// Latency: 4 cycles per non-memory instruction, 5 per LOAD/STORE with same-cycle acks; each ack wait cycle adds 1.
// Backpressure: imem_ack/dmem_ack hold FETCH/MEM; run=0 parks in IDLE at the WB boundary. Optional TRAP state under CORE_SEQ_TRAP_EN.
module core_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_we,
  output logic        trap,
  input  logic        trap_ack,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  // Opcode class captured at DECODE so later opcode changes are harmless.
  logic        cls_mem_q, cls_mem_d;
  logic        cls_store_q, cls_store_d;
  logic        cls_rf_q, cls_rf_d;

  logic        is_mem_c;
  logic        is_store_c;
  logic        writes_rf_c;
  logic        is_bad_c;

  // Classify the live opcode; only sampled while in DECODE.
  always_comb begin
    is_mem_c    = 1'b0;
    is_store_c  = 1'b0;
    writes_rf_c = 1'b0;
    is_bad_c    = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ALUI, OP_ALUR: writes_rf_c = 1'b1;
      OP_LOAD: begin
        is_mem_c    = 1'b1;
        writes_rf_c = 1'b1;
      end
      OP_STORE: begin
        is_mem_c   = 1'b1;
        is_store_c = 1'b1;
      end
      OP_BRANCH: ;
      OP_SYSTEM: is_bad_c = 1'b1;
      default:   is_bad_c = 1'b1;
    endcase
  end

`ifndef CORE_SEQ_TRAP_EN
  // Without the trap state, SYSTEM/illegal run as NOPs and the acknowledge has no consumer.
  logic trap_ack_unused;
  logic is_bad_unused;
  assign trap_ack_unused = trap_ack;
  assign is_bad_unused   = is_bad_c;
`endif

  // Next-state, Moore strobes, Mealy ir_we and counter update.
  always_comb begin
    state_d     = state_q;
    instret_d   = instret_q;
    cls_mem_d   = cls_mem_q;
    cls_store_d = cls_store_q;
    cls_rf_d    = cls_rf_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    alu_en      = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    trap        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        cls_mem_d   = is_mem_c;
        cls_store_d = is_store_c;
        cls_rf_d    = writes_rf_c;
`ifdef CORE_SEQ_TRAP_EN
        state_d = is_bad_c ? S_TRAP : S_EXECUTE;
`else
        state_d = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        alu_en  = 1'b1;
        state_d = cls_mem_q ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls_store_q;
        if (dmem_ack) state_d = S_WB;
      end
      S_WB: begin
        pc_we     = 1'b1;
        rf_we     = cls_rf_q;
        instret_d = instret_q + 32'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
`ifdef CORE_SEQ_TRAP_EN
      S_TRAP: begin
        trap = 1'b1;
        if (trap_ack) state_d = run ? S_FETCH : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, class and counter registers; reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instret_q   <= 32'd0;
      cls_mem_q   <= 1'b0;
      cls_store_q <= 1'b0;
      cls_rf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instret_q   <= instret_d;
      cls_mem_q   <= cls_mem_d;
      cls_store_q <= cls_store_d;
      cls_rf_q    <= cls_rf_d;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule
